dmem_access_ctrl: RTL

Sequencing controller between the S-Machine CPU load/store datapath and the data memory. The data memory updates whenever its address or `read_write` changes, so this block turns a single-cycle CPU request into a glitch-free, multi-cycle memory transaction: address and data first, then the write strobe, then the result. It also owns the memory-mapped switch input, synchronising and debouncing the raw pin before it reaches memory word 4. It also blocks CPU writes to that read-only word.

---
 rtl/smachine_pkg.sv | 18 +
 rtl/dmem_access_ctrl_if.sv | 30 +++
 rtl/switch_debounce.sv | 47 ++++
 rtl/dmem_access_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/smachine_pkg.sv
// Shared S-Machine definitions: memory-access FSM states, bus widths and
// the memory-map addresses used by the data-memory controller.
package smachine_pkg;

  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 16;

  localparam int LED_ADDR    = 0;
  localparam int SWITCH_ADDR = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } state_e;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// CPU request/response and data-memory signals of the access controller.
// The master side is the CPU + memory environment; the slave side is the controller.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = smachine_pkg::ADDR_W,
  parameter int DATA_W = smachine_pkg::DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              ready;
  logic              busy;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req, we, cpu_addr, cpu_wdata, mem_rdata,
    input  ready, busy, cpu_rdata, mem_addr, mem_wdata, mem_rw
  );

  modport slave (
    input  req, we, cpu_addr, cpu_wdata, mem_rdata,
    output ready, busy, cpu_rdata, mem_addr, mem_wdata, mem_rw
  );

endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a stability counter; clean only follows
// the synchronised input after DEBOUNCE_CYCLES consecutive differing samples.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean
);

  localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES - 1);

  logic       meta_q, sync_q, clean_q;
  logic       clean_d;
  logic [7:0] cnt_q, cnt_d;

  // The counter tops out at LIMIT and clears there, so it can never wrap.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = 8'd0;
    if (sync_q != clean_q) begin
      if (cnt_q >= LIMIT) begin
        clean_d = sync_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      meta_q  <= raw;
      sync_q  <= meta_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Turns a one-cycle CPU load/store request into a glitch-free memory
// transaction (address, then strobe, then result) and debounces the switch.
module dmem_access_ctrl #(
  parameter int ADDR_W          = smachine_pkg::ADDR_W,
  parameter int DATA_W          = smachine_pkg::DATA_W,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SWITCH_ADDR     = smachine_pkg::SWITCH_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  dmem_access_ctrl_if.slave  bus,
  input  logic               switch_raw,
  output logic               switch_clean
);

  smachine_pkg::state_e state_q, state_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rw_q, rw_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rw_d    = 1'b0;
    ready_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      smachine_pkg::IDLE: begin
        if (bus.req) begin
          state_d = smachine_pkg::SETUP;
          we_d    = bus.we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          busy_d  = 1'b1;
        end
      end
      smachine_pkg::SETUP: begin
        // Strobe rises one cycle after the address settled; the switch word is read-only.
        state_d = smachine_pkg::STROBE;
        rw_d    = we_q && (addr_q != ADDR_W'(SWITCH_ADDR));
      end
      smachine_pkg::STROBE: begin
        state_d = smachine_pkg::DONE;
        ready_d = 1'b1;
        if (!we_q) rdata_d = bus.mem_rdata;
      end
      smachine_pkg::DONE: begin
        state_d = smachine_pkg::IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = smachine_pkg::IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= smachine_pkg::IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_rw    = rw_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.cpu_rdata = rdata_q;

  switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_switch_debounce (
    .clk  (clk),
    .rst  (rst),
    .raw  (switch_raw),
    .clean(switch_clean)
  );

endmodule
